// File: rtl/crc_engine_pkg.sv
// Shared types, register-field bit positions and helpers for the CRC-32 engine.
package crc_engine_pkg;

  // CRC_CONTROL field positions
  localparam int unsigned CRC_CTRL_ENABLE_BIT = 0;
  localparam int unsigned CRC_CTRL_CLEAR_BIT  = 1;

  // CRC_STATUS field positions
  localparam int unsigned CRC_STAT_BUSY_BIT    = 0;
  localparam int unsigned CRC_STAT_DONE_BIT    = 1;
  localparam int unsigned CRC_STAT_OVERRUN_BIT = 2;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Wide enough for a full word at one bit per cycle (32).
  localparam int unsigned CRC_CNT_W = 6;

  typedef enum logic {CRC_IDLE, CRC_SHIFT} crc_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Bit-reverse each byte in place; byte order is preserved.
  function automatic logic [31:0] reflect_bytes(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = v[8*b+7-i];
      end
    end
    return r;
  endfunction

  // Lengths 0 and 5-7 are treated as a full word.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    logic [2:0] r;
    r = len;
    if ((len == 3'd0) || (len > 3'd4)) begin
      r = 3'd4;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_engine_bit_step.sv
// Combinational CRC fold of BITS_PER_CYCLE bits, MSB-first, into a 32-bit CRC.
module crc_bit_step
  import crc_engine_pkg::*;
#(
  parameter logic [31:0] POLY           = CRC32_POLY,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic [31:0]               crc_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [31:0]               crc_o
);

  logic [31:0] crc;
  logic        fb;

  always_comb begin
    crc = crc_i;
    fb  = 1'b0;
    for (int i = int'(BITS_PER_CYCLE) - 1; i >= 0; i--) begin
      fb  = crc[31] ^ bits_i[i];
      crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    crc_o = crc;
  end

endmodule

// File: rtl/crc_engine.sv
// CRC-32 datapath behind CRC_CONTROL/STATUS/INPUT/OUTPUT; folds 1-4 bytes per word.
// Define CRC_REFLECT_EN for the reflected (bit-reversed bytes and output) variant.
module crc_engine
  import crc_engine_pkg::*;
#(
  parameter logic [31:0] POLY           = CRC32_POLY,
  parameter logic [31:0] INIT           = CRC32_INIT,
  parameter logic [31:0] XOR_OUT        = 32'h00000000,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_len,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [31:0] crc_out
);

  crc_state_t           state_q, state_d;
  logic [31:0]          crc_q, crc_d;
  logic [31:0]          shift_q, shift_d;
  logic [CRC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic [31:0] crc_step;
  logic [31:0] load_data;
  logic [1:0]  ctrl;
  logic [2:0]  status;
  logic        ctrl_enable;
  logic        ctrl_clear;
  logic        accept;

  assign ctrl[CRC_CTRL_ENABLE_BIT] = enable;
  assign ctrl[CRC_CTRL_CLEAR_BIT]  = clear;
  assign ctrl_enable = ctrl[CRC_CTRL_ENABLE_BIT];
  assign ctrl_clear  = ctrl[CRC_CTRL_CLEAR_BIT];

  assign in_ready = ctrl_enable && (state_q == CRC_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef CRC_REFLECT_EN
  assign load_data = reflect_bytes(in_data);
  assign crc_out   = reflect32(crc_q) ^ XOR_OUT;
`else
  assign load_data = in_data;
  assign crc_out   = crc_q ^ XOR_OUT;
`endif

  crc_bit_step #(
    .POLY          (POLY),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .crc_i (crc_q),
    .bits_i(shift_q[31 -: BITS_PER_CYCLE]),
    .crc_o (crc_step)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    overrun_d = overrun_q;

    if (ctrl_clear) begin
      // Clear wins over any same-cycle write, which is dropped silently.
      state_d   = CRC_IDLE;
      crc_d     = INIT;
      shift_d   = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        CRC_IDLE: begin
          if (accept) begin
            shift_d = load_data;
            cnt_d   = CRC_CNT_W'((32'(eff_len(in_len)) * 32'd8) / BITS_PER_CYCLE);
            done_d  = 1'b0;
            state_d = CRC_SHIFT;
          end
        end
        CRC_SHIFT: begin
          crc_d   = crc_step;
          shift_d = shift_q << BITS_PER_CYCLE;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CRC_CNT_W'(1)) begin
            state_d = CRC_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = CRC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= CRC_IDLE;
      crc_q     <= INIT;
      shift_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign status[CRC_STAT_BUSY_BIT]    = (state_q == CRC_SHIFT);
  assign status[CRC_STAT_DONE_BIT]    = done_q;
  assign status[CRC_STAT_OVERRUN_BIT] = overrun_q;

  assign busy    = status[CRC_STAT_BUSY_BIT];
  assign done    = status[CRC_STAT_DONE_BIT];
  assign overrun = status[CRC_STAT_OVERRUN_BIT];

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: four instances (8/4/2/1 bits per cycle) share one stimulus.
module tb_crc_engine;

  localparam int unsigned NumDut = 4;
`ifdef CRC_REFLECT_EN
  localparam logic [31:0] TbXorOut = 32'hFFFFFFFF;
  localparam logic [31:0] ExpCheck = 32'hCBF43926;
  localparam logic [31:0] ExpReset = 32'h00000000;
`else
  localparam logic [31:0] TbXorOut = 32'h00000000;
  localparam logic [31:0] ExpCheck = 32'h0376E6E7;
  localparam logic [31:0] ExpReset = 32'hFFFFFFFF;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        enable;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_len;

  logic        in_ready_w [NumDut];
  logic        busy_w     [NumDut];
  logic        done_w     [NumDut];
  logic        overrun_w  [NumDut];
  logic [31:0] crc_w      [NumDut];

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    crc_engine #(
      .POLY          (32'h04C11DB7),
      .INIT          (32'hFFFFFFFF),
      .XOR_OUT       (TbXorOut),
      .BITS_PER_CYCLE(8 >> g)
    ) u_dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .enable  (enable),
      .clear   (clear),
      .in_valid(in_valid),
      .in_data (in_data),
      .in_len  (in_len),
      .in_ready(in_ready_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .overrun (overrun_w[g]),
      .crc_out (crc_w[g])
    );
  end

  function automatic int bpc_of(input int g);
    return 8 >> g;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare one output of every instance against a single expected value.
  task automatic check_all(input string tag, input int sel, input logic [31:0] exp);
    logic [31:0] v;
    for (int g = 0; g < NumDut; g++) begin
      unique case (sel)
        0: v = 32'(in_ready_w[g]);
        1: v = 32'(busy_w[g]);
        2: v = 32'(done_w[g]);
        3: v = 32'(overrun_w[g]);
        default: v = crc_w[g];
      endcase
      check_eq($sformatf("%s bpc%0d", tag, bpc_of(g)), v, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic [2:0] l);
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Wait (bounded) for done on every instance; skip = cycles already elapsed since accept.
  task automatic wait_done(input string tag, input int nbytes, input int skip);
    int lat [NumDut];
    bit seen[NumDut];
    bit all_seen;
    for (int g = 0; g < NumDut; g++) begin
      lat[g]  = 0;
      seen[g] = 1'b0;
    end
    all_seen = 1'b0;
    for (int c = 1; c <= 64 && !all_seen; c++) begin
      tick();
      all_seen = 1'b1;
      for (int g = 0; g < NumDut; g++) begin
        if (!seen[g] && done_w[g]) begin
          seen[g] = 1'b1;
          lat[g]  = c;
        end
        all_seen &= seen[g];
      end
    end
    for (int g = 0; g < NumDut; g++) begin
      check_eq($sformatf("%s lat bpc%0d", tag, bpc_of(g)), 32'(lat[g]),
               32'(nbytes * 8 / bpc_of(g) - skip));
    end
  endtask

  task automatic run_string(input string tag, input logic [2:0] len_a, input logic [2:0] len_b);
    write_word(32'h31323334, len_a);
    wait_done({tag, " w0"}, 4, 0);
    write_word(32'h35363738, len_b);
    wait_done({tag, " w1"}, 4, 0);
    write_word(32'h39000000, 3'd1);
    wait_done({tag, " w2"}, 1, 0);
    check_all({tag, " done"}, 2, 32'd1);
    check_all({tag, " crc"}, 4, ExpCheck);
  endtask

  initial begin
    n_rst    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    repeat (2) tick();

    check_all("rst busy", 1, 32'd0);
    check_all("rst done", 2, 32'd0);
    check_all("rst ovr", 3, 32'd0);
    check_all("rst rdy", 0, 32'd1);
    check_all("rst crc", 4, ExpReset);
    n_rst = 1'b1;
    tick();

    // Check string "123456789"
    run_string("str", 3'd4, 3'd4);

    // Length codes 0 and 7 mean a full word
    pulse_clear();
    check_all("clr crc", 4, ExpReset);
    check_all("clr done", 2, 32'd0);
    run_string("len07", 3'd0, 3'd7);

    // Write while busy is dropped and flagged
    pulse_clear();
    write_word(32'h31323334, 3'd4);
    check_all("ovr busy", 1, 32'd1);
    check_all("ovr rdy", 0, 32'd0);
    write_word(32'hDEADBEEF, 3'd4);
    check_all("ovr flag", 3, 32'd1);
    wait_done("ovr w0", 4, 1);
    write_word(32'h35363738, 3'd4);
    wait_done("ovr w1", 4, 0);
    write_word(32'h39000000, 3'd1);
    wait_done("ovr w2", 1, 0);
    check_all("ovr crc", 4, ExpCheck);
    check_all("ovr sticky", 3, 32'd1);

    // Clear on the second SHIFT cycle aborts the word and clears both flags
    write_word(32'h31323334, 3'd4);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_all("abort busy", 1, 32'd0);
    check_all("abort done", 2, 32'd0);
    check_all("abort ovr", 3, 32'd0);
    check_all("abort crc", 4, ExpReset);
    run_string("rerun", 3'd4, 3'd4);

    // Clear together with a write: word dropped, no overrun
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h31323334;
    in_len   = 3'd4;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_all("clrwr busy", 1, 32'd0);
    check_all("clrwr ovr", 3, 32'd0);
    check_all("clrwr crc", 4, ExpReset);

    // Enable low: not ready, writes flag overrun and leave the CRC alone
    enable = 1'b0;
    #1;
    check_all("dis rdy", 0, 32'd0);
    write_word(32'h31323334, 3'd4);
    check_all("dis ovr", 3, 32'd1);
    check_all("dis busy", 1, 32'd0);
    check_all("dis crc", 4, ExpReset);
    enable = 1'b1;
    pulse_clear();

    // Enable falling mid-word lets the current word finish
    write_word(32'h31323334, 3'd4);
    enable = 1'b0;
    wait_done("efall w0", 4, 0);
    check_all("efall rdy", 0, 32'd0);
    check_all("efall ovr", 3, 32'd0);
    enable = 1'b1;
    #1;
    check_all("efall rdy2", 0, 32'd1);
    write_word(32'h35363738, 3'd4);
    wait_done("efall w1", 4, 0);
    write_word(32'h39000000, 3'd1);
    wait_done("efall w2", 1, 0);
    check_all("efall crc", 4, ExpCheck);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
